// File: rtl/switch_debounce_dev_if.sv
// Processor data-bus address/strobe bundle for memory-mapped devices.
// DBUS stays a plain inout net on the device because it is a shared tri-state wire.
interface switch_debounce_dev_if #(
   parameter int BITS = 32
);
   logic [BITS-1:0] ABUS;
   logic            WE;

   modport master (output ABUS, output WE);
   modport slave  (input  ABUS, input  WE);
endinterface

// File: rtl/switch_debounce_dev.sv
// Switch input device: two-flop sync, debounce, SDATA/SCTRL registers on the data bus.
// Software polls Ready/Overflow in SCTRL or takes intr = Ready & IE.
module switch_debounce_dev #(
   parameter int              BITS            = 32,
   parameter logic [BITS-1:0] BASE            = 'hF0000014,
   parameter int              SW_BITS         = 10,
   parameter int              DEBOUNCE_CYCLES = 4,
   parameter int              CNT_BITS        = 16
) (
   input  logic                clk,
   input  logic                reset,
   switch_debounce_dev_if.slave bus,
   inout  wire  [BITS-1:0]     DBUS,
   input  logic [SW_BITS-1:0]  SW,
   output logic                intr
);

   localparam logic [BITS-1:0]     CTRL_A = BASE + BITS'(4);
   localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   logic [SW_BITS-1:0]  sync1_q, sync2_q;
   logic [SW_BITS-1:0]  cand_q, cand_d;
   logic [SW_BITS-1:0]  deb_q, deb_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic                oe_q, oe_d;
   logic                ie_q, ie_d;
   logic                evt;
   logic                hit_data, hit_ctrl;
   logic                data_rd, ctrl_rd, ctrl_wr, rd_en;
   logic [BITS-1:0]     rdata;
   logic                unused_dbus;

   assign hit_data = (bus.ABUS == BASE);
   assign hit_ctrl = (bus.ABUS == CTRL_A);
   assign data_rd  = !bus.WE && hit_data;
   assign ctrl_rd  = !bus.WE && hit_ctrl;
   assign ctrl_wr  = bus.WE && hit_ctrl;
   assign rd_en    = data_rd || ctrl_rd;

   always_comb begin
      cand_d = cand_q;
      deb_d  = deb_q;
      cnt_d  = cnt_q;
      evt    = 1'b0;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cand_q != deb_q) begin
         if (cnt_q == LAST) begin
            deb_d = cand_q;
            cnt_d = '0;
            evt   = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // A new value wins over a same-edge clear, for both Ready and OE.
   always_comb begin
      ready_d = ready_q;
      oe_d    = oe_q;
      ie_d    = ie_q;
      if (evt)
         ready_d = 1'b1;
      else if (data_rd)
         ready_d = 1'b0;
      if (evt && ready_q && !data_rd)
         oe_d = 1'b1;
      else if (ctrl_wr && !DBUS[2])
         oe_d = 1'b0;
      if (ctrl_wr)
         ie_d = DBUS[8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         deb_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         oe_q    <= 1'b0;
         ie_q    <= 1'b0;
      end else begin
         sync1_q <= SW;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         oe_q    <= oe_d;
         ie_q    <= ie_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (data_rd) begin
         rdata[SW_BITS-1:0] = deb_q;
      end else begin
         rdata[0] = ready_q;
         rdata[2] = oe_q;
         rdata[8] = ie_q;
      end
   end

   assign DBUS = rd_en ? rdata : 'z;
   assign intr = ready_q & ie_q;

   assign unused_dbus = ^{DBUS[BITS-1:9], DBUS[7:3], DBUS[1:0]};

endmodule

// File: tb/tb_switch_debounce_dev.sv
// Directed bench for switch_debounce_dev: register-map table plus
// hand-written debounce timing, glitch, overflow, interrupt and reset sequences.
module tb_switch_debounce_dev;

   localparam logic [31:0] BASE  = 32'hF0000014;
   localparam logic [31:0] CTRL  = 32'hF0000018;
   localparam logic [31:0] IDLE  = 32'h00000000;
   localparam logic [31:0] UNMAP = 32'hF000001C;

   typedef struct {
      int          ph;
      string       nm;
      int          op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      logic        exp_intr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  sw;
   logic        intr;
   logic [31:0] wdata;
   logic        drv;
   wire  [31:0] dbus;

   int errors = 0;
   int checks = 0;

   vec_t tbl[$];

   switch_debounce_dev_if #(.BITS(32)) bus ();

   assign dbus = drv ? wdata : 'z;

   switch_debounce_dev dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .DBUS  (dbus),
      .SW    (sw),
      .intr  (intr)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Combinational read with no clock edge, so no side effect.
   task automatic peek(input string nm, input logic [31:0] a,
                       input logic [31:0] exp, input logic ei);
      bus.ABUS = a;
      bus.WE   = 1'b0;
      drv      = 1'b0;
      #1;
      check(nm, dbus, exp);
      check({nm, "_intr"}, {31'd0, intr}, {31'd0, ei});
      bus.ABUS = IDLE;
   endtask

   // Read presented across a clock edge (triggers side effects).
   task automatic rd_edge(input logic [31:0] a);
      bus.ABUS = a;
      bus.WE   = 1'b0;
      drv      = 1'b0;
      tick(1);
      bus.ABUS = IDLE;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.ABUS = a;
      bus.WE   = 1'b1;
      wdata    = d;
      drv      = 1'b1;
      tick(1);
      bus.WE   = 1'b0;
      drv      = 1'b0;
      bus.ABUS = IDLE;
   endtask

   task automatic add(input int ph, input string nm, input int op,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e, input logic ei);
      vec_t v;
      v.ph = ph; v.nm = nm; v.op = op;
      v.addr = a; v.data = d; v.exp = e; v.exp_intr = ei;
      tbl.push_back(v);
   endtask

   task automatic run_ph(input int p);
      foreach (tbl[i]) begin
         if (tbl[i].ph == p) begin
            case (tbl[i].op)
               0: peek(tbl[i].nm, tbl[i].addr, tbl[i].exp, tbl[i].exp_intr);
               1: wr(tbl[i].addr, tbl[i].data);
               default: rd_edge(tbl[i].addr);
            endcase
         end
      end
   endtask

   initial begin
      // op: 0 = peek/compare, 1 = write, 2 = read across an edge
      add(1, "rst_unmap", 0, 32'hF0000010, 0, 32'h0, 1'b0);
      add(1, "rst_sdata", 0, BASE, 0, 32'h0, 1'b0);
      add(1, "rst_sctrl", 0, CTRL, 0, 32'h0, 1'b0);

      add(4, "two_chg",   0, CTRL, 0, 32'h5, 1'b0);
      add(4, "sdata7",    0, BASE, 0, 32'h7, 1'b0);
      add(4, "",          1, CTRL, 32'h4, 0, 1'b0);
      add(4, "oe_w1",     0, CTRL, 0, 32'h5, 1'b0);
      add(4, "",          1, CTRL, 32'h0, 0, 1'b0);
      add(4, "oe_clr",    0, CTRL, 0, 32'h1, 1'b0);
      add(4, "",          1, CTRL, 32'h5, 0, 1'b0);
      add(4, "oe_noset",  0, CTRL, 0, 32'h1, 1'b0);
      add(4, "",          1, BASE, 32'hFFFFFFFF, 0, 1'b0);
      add(4, "",          1, UNMAP, 32'h104, 0, 1'b0);
      add(4, "sdata_ro",  0, BASE, 0, 32'h7, 1'b0);
      add(4, "unmap_wr",  0, CTRL, 0, 32'h1, 1'b0);

      add(5, "",          2, BASE, 0, 0, 1'b0);
      add(5, "",          1, CTRL, 32'h100, 0, 1'b0);
      add(5, "ie_set",    0, CTRL, 0, 32'h100, 1'b0);

      reset    = 1'b1;
      sw       = '0;
      bus.ABUS = IDLE;
      bus.WE   = 1'b0;
      wdata    = '0;
      drv      = 1'b0;
      tick(3);
      reset = 1'b0;

      run_ph(1);

      // Latency: visible after edge 7, not edge 6
      sw = 10'h155;
      tick(6);
      peek("lat_e6", BASE, 32'h0, 1'b0);
      tick(1);
      peek("lat_e7", BASE, 32'h155, 1'b0);
      peek("rdy_set", CTRL, 32'h1, 1'b0);
      peek("undriven", UNMAP, 32'h0, 1'b0);
      rd_edge(BASE);
      peek("rdy_clr", CTRL, 32'h0, 1'b0);

      // Return to 0, then glitch train never accepted
      sw = 10'h000;
      tick(8);
      rd_edge(BASE);
      peek("back0", BASE, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         sw = 10'h001;
         tick(2);
         sw = 10'h000;
         tick(2);
      end
      peek("glitch_deb", BASE, 32'h0, 1'b0);
      tick(10);
      peek("glitch_rdy", CTRL, 32'h0, 1'b0);

      // Two accepted changes without a read -> overflow
      sw = 10'h003;
      tick(7);
      sw = 10'h007;
      tick(7);
      run_ph(4);

      // Interrupt enable and Ready/intr timing
      run_ph(5);
      sw = 10'h00F;
      tick(6);
      peek("intr_e6", CTRL, 32'h100, 1'b0);
      tick(1);
      peek("intr_e7", CTRL, 32'h101, 1'b1);
      rd_edge(BASE);
      peek("intr_clr", CTRL, 32'h100, 1'b0);
      sw = 10'h01F;
      tick(7);
      peek("rdy_again", CTRL, 32'h101, 1'b1);

      // Event on the same edge as an SDATA read: Ready kept, no OE
      sw = 10'h03F;
      tick(6);
      rd_edge(BASE);
      peek("coinc_ctl", CTRL, 32'h101, 1'b1);
      peek("coinc_dat", BASE, 32'h3F, 1'b1);

      // Reset in the middle of a debounce
      sw = 10'h3FF;
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      peek("mid_sdata", BASE, 32'h0, 1'b0);
      peek("mid_sctrl", CTRL, 32'h0, 1'b0);
      tick(6);
      peek("post_e6", CTRL, 32'h0, 1'b0);
      tick(1);
      peek("post_e7", CTRL, 32'h1, 1'b0);
      peek("post_dat", BASE, 32'h3FF, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
